// File: rtl/ps2_letter_input_pkg.sv
// Shared constants for the PS/2 letter front end: scan codes, letter table, 7-seg glyphs.
package ps2_letter_input_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Make codes in letter order, index 0 = A ... 25 = Z.
    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } letter_hit_t;

    function automatic letter_hit_t letter_lookup(input logic [7:0] code);
        letter_hit_t r;
        r = '0;
        for (int i = 0; i < 26; i++) begin
            if (code == LETTER_CODES[i]) begin
                r.hit = 1'b1;
                r.idx = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_letter_input_if.sv
// Scan-code handshake and decoded-letter bus between the keyboard front end and its consumer.
interface ps2_letter_input_if;
    logic        read;
    logic        scan_ready;
    logic [7:0]  scan_code;
    logic        parity_err;
    logic [25:0] letter;
    logic        letter_valid;

    // Front end sources data, consumer acknowledges with read.
    modport master (
        input  read,
        output scan_ready, scan_code, parity_err, letter, letter_valid
    );
    modport slave (
        output read,
        input  scan_ready, scan_code, parity_err, letter, letter_valid
    );
endinterface

// File: rtl/seg7_hex.sv
// One hex digit to an active-low 7-segment glyph.
module seg7_hex
    import ps2_letter_input_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    // Pure table lookup.
    always_comb begin
        seg_o = SEG_PATTERNS[digit_i];
    end
endmodule

// File: rtl/ps2_letter_input.sv
// PS/2 receiver with scan-code handshake, A-Z one-hot decoder and two hex displays.
module ps2_letter_input
    import ps2_letter_input_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic               clock50,
    input  logic               reset,
    input  logic               keyboard_clk,
    input  logic               keyboard_data,
    ps2_letter_input_if.master bus,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1
);
    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]      kclk_sync_q, kdat_sync_q;
    logic            kclk_filt_q, kclk_filt_d;
    logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      frame_q, frame_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            scan_ready_q, scan_ready_d;
    logic            parity_err_q, parity_err_d;
    logic [25:0]     letter_q, letter_d;
    logic            letter_valid_q, letter_valid_d;
    logic            brk_q, brk_d;
    logic            fall, frame_done, frame_ok;
    logic [7:0]      rx_byte;
    letter_hit_t     lk;

    // Glitch filter: the filtered clock follows the raw level only after FILTER_LEN
    // consecutive samples that disagree with it.
    always_comb begin
        kclk_filt_d = kclk_filt_q;
        flt_cnt_d   = '0;
        if (kclk_sync_q[1] != kclk_filt_q) begin
            if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
                kclk_filt_d = kclk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FltW'(1);
            end
        end
        fall = kclk_filt_q & ~kclk_filt_d;
    end

    // Frame shifter, bit counter and inactivity timeout.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        to_cnt_d   = '0;
        frame_done = 1'b0;
        frame_ok   = 1'b0;
        if (fall) begin
            if (bit_cnt_q == 4'd10) begin
                // frame_q = {parity, d7..d0, start}; current data bit is the stop bit.
                bit_cnt_d  = '0;
                frame_done = 1'b1;
                frame_ok   = ~frame_q[0] & kdat_sync_q[1] & (^frame_q[9:1]);
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                frame_d   = {kdat_sync_q[1], frame_q[9:1]};
            end
        end else if (bit_cnt_q != '0) begin
            if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + ToW'(1);
            end
        end
    end

    assign rx_byte = frame_q[8:1];
    assign lk      = letter_lookup(rx_byte);

    // Handshake, break tracking and letter decode; a completing frame beats a read.
    always_comb begin
        scan_code_d    = scan_code_q;
        scan_ready_d   = scan_ready_q;
        parity_err_d   = 1'b0;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        brk_d          = brk_q;
        if (frame_done && frame_ok) begin
            scan_code_d  = rx_byte;
            scan_ready_d = 1'b1;
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else if (rx_byte != SC_EXT && lk.hit) begin
                letter_d       = 26'(1) << lk.idx;
                letter_valid_d = 1'b1;
            end
        end else begin
            parity_err_d = frame_done;
            if (bus.read) begin
                scan_ready_d = 1'b0;
            end
        end
    end

    // State registers; PS/2 lines idle high so synchronizers reset to 1.
    always_ff @(posedge clock50 or negedge reset) begin
        if (!reset) begin
            kclk_sync_q    <= 2'b11;
            kdat_sync_q    <= 2'b11;
            kclk_filt_q    <= 1'b1;
            flt_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            frame_q        <= '0;
            to_cnt_q       <= '0;
            scan_code_q    <= '0;
            scan_ready_q   <= 1'b0;
            parity_err_q   <= 1'b0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            brk_q          <= 1'b0;
        end else begin
            kclk_sync_q    <= {kclk_sync_q[0], keyboard_clk};
            kdat_sync_q    <= {kdat_sync_q[0], keyboard_data};
            kclk_filt_q    <= kclk_filt_d;
            flt_cnt_q      <= flt_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_q        <= frame_d;
            to_cnt_q       <= to_cnt_d;
            scan_code_q    <= scan_code_d;
            scan_ready_q   <= scan_ready_d;
            parity_err_q   <= parity_err_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            brk_q          <= brk_d;
        end
    end

    assign bus.scan_ready   = scan_ready_q;
    assign bus.scan_code    = scan_code_q;
    assign bus.parity_err   = parity_err_q;
    assign bus.letter       = letter_q;
    assign bus.letter_valid = letter_valid_q;

    seg7_hex u_hex0 (
        .digit_i (scan_code_q[3:0]),
        .seg_o   (HEX0)
    );

    seg7_hex u_hex1 (
        .digit_i (scan_code_q[7:4]),
        .seg_o   (HEX1)
    );
endmodule

// File: tb/tb_ps2_letter_input.sv
// Bench for ps2_letter_input: directed scenarios then randomized frames against a byte-level model.
module tb_ps2_letter_input;
    localparam int unsigned TimeoutCyc = 2000;
    localparam int          Hp         = 25;   // PS/2 half bit period in clock50 cycles

    logic       clock50 = 1'b0;
    logic       reset   = 1'b0;
    logic       kb_clk  = 1'b1;
    logic       kb_data = 1'b1;
    logic [6:0] hex0, hex1;

    ps2_letter_input_if bus_if ();

    ps2_letter_input #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clock50       (clock50),
        .reset         (reset),
        .keyboard_clk  (kb_clk),
        .keyboard_data (kb_data),
        .bus           (bus_if),
        .HEX0          (hex0),
        .HEX1          (hex1)
    );

    always #10 clock50 = ~clock50;

    logic [7:0] letter_codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0]  m_code   = 8'h00;
    logic        m_ready  = 1'b0;
    logic [25:0] m_letter = '0;
    bit          m_brk    = 1'b0;
    int          exp_lv, exp_pe;

    // Pulse counters, sampled away from the active edge.
    int lv_seen = 0;
    int pe_seen = 0;
    int lv_base, pe_base;
    always @(negedge clock50) begin
        if (bus_if.letter_valid === 1'b1) lv_seen++;
        if (bus_if.parity_err === 1'b1) pe_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_code = 8'h00; m_ready = 1'b0; m_letter = '0; m_brk = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        exp_lv = 0;
        exp_pe = 0;
        if (!good) begin
            exp_pe = 1;
            return;
        end
        m_code  = b;
        m_ready = 1'b1;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
        end else if (b != 8'hE0) begin
            for (int i = 0; i < 26; i++) begin
                if (letter_codes[i] == b) begin
                    m_letter = 26'd1 << i;
                    exp_lv   = 1;
                end
            end
        end
    endtask

    task automatic ps2_bit(input logic v, input bit glitch);
        kb_data = v;
        if (glitch) begin
            repeat (8) @(negedge clock50);
            kb_clk = 1'b0;
            repeat (4) @(negedge clock50);
            kb_clk = 1'b1;
            repeat (Hp - 12) @(negedge clock50);
        end else begin
            repeat (Hp) @(negedge clock50);
        end
        kb_clk = 1'b0;
        repeat (Hp) @(negedge clock50);
        kb_clk = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".scan_code"}, 32'(bus_if.scan_code), 32'(m_code));
        check({tag, ".scan_ready"}, 32'(bus_if.scan_ready), 32'(m_ready));
        check({tag, ".letter"}, 32'(bus_if.letter), 32'(m_letter));
        check({tag, ".hex0"}, 32'(hex0), 32'(seg_ref[m_code[3:0]]));
        check({tag, ".hex1"}, 32'(hex1), 32'(seg_ref[m_code[7:4]]));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par,
                            input int glitch_bit);
        logic [10:0] f;
        f       = make_frame(b, bad_par);
        lv_base = lv_seen;
        pe_base = pe_seen;
        for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
        repeat (Hp) @(negedge clock50);
        model_frame(b, !bad_par);
        check_state(tag);
        check({tag, ".lv_pulses"}, 32'(lv_seen - lv_base), 32'(exp_lv));
        check({tag, ".pe_pulses"}, 32'(pe_seen - pe_base), 32'(exp_pe));
    endtask

    task automatic pulse_read(input string tag);
        bus_if.read = 1'b1;
        @(negedge clock50);
        bus_if.read = 1'b0;
        m_ready = 1'b0;
        check({tag, ".ready_clr"}, 32'(bus_if.scan_ready), 32'(m_ready));
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        bus_if.read = 1'b0;
        repeat (5) @(negedge clock50);
        check_state("reset");
        check("reset.lv", 32'(bus_if.letter_valid), 32'd0);
        check("reset.pe", 32'(bus_if.parity_err), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock50);

        do_frame("a_1c", 8'h1C, 1'b0, -1);
        pulse_read("a_read");
        check_state("a_after_read");

        do_frame("brk_f0", 8'hF0, 1'b0, -1);
        do_frame("brk_1c", 8'h1C, 1'b0, -1);
        do_frame("z_1a", 8'h1A, 1'b0, -1);
        pulse_read("z_read");

        do_frame("bad_par", 8'h1C, 1'b1, -1);

        // Partial frame then an idle gap longer than the timeout.
        f = make_frame(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(f[i], 1'b0);
        repeat (TimeoutCyc + 1000) @(negedge clock50);
        do_frame("timeout_32", 8'h32, 1'b0, -1);

        do_frame("glitch_44", 8'h44, 1'b0, 5);

        // Reset in the middle of a frame.
        f = make_frame(8'h2B, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(f[i], 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        check_state("midreset");
        repeat (3) @(negedge clock50);
        kb_data = 1'b1;
        reset   = 1'b1;
        repeat (5) @(negedge clock50);
        do_frame("post_reset_1c", 8'h1C, 1'b0, -1);

        // Randomized frames mixing letters, prefixes, arbitrary bytes and bad parity.
        for (int n = 0; n < 24; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      b = letter_codes[$urandom_range(0, 25)];
            else if (sel == 6) b = 8'hF0;
            else if (sel == 7) b = 8'hE0;
            else               b = 8'($urandom);
            do_frame("rand", b, ($urandom_range(0, 5) == 0), -1);
            if ($urandom_range(0, 1) == 1) pulse_read("rand_read");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
